mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory-port arbiter between the instruction-side fetch engine (I) and the data memory engine (D) on one side and the shared external memory port on the other. It grants requests round-robin and registers the winner onto the single downstream request channel. Each read gets a unique transaction ID, and the block keeps an outstanding-read table. Read responses, which may return out of order, are routed back to the owning requester by ID.

## Interface
Parameters:
- PA_WIDTH, 32: physical address width.
- REG_WIDTH, 32: store data width.
- LINE_WIDTH, 128: response (cache line) width.
- ID_WIDTH, 4: transaction ID width; the ID table has 2^ID_WIDTH entries.
- MAX_OUTSTANDING, 4: maximum in-flight reads. Must be ≤ 2^ID_WIDTH.

Ports (r ∈ {i, d}, one set per requester):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- i_r_req  in  1  request valid; held until granted.
- i_r_addr  in  PA_WIDTH  request address.
- i_r_data  in  REG_WIDTH  store data; ignored for reads.
- i_r_write  in  1  1 = posted write, 0 = read.
- o_r_grant  out  1  combinational; request accepted this cycle.
- o_r_id  out  ID_WIDTH  ID assigned to the granted read; valid with o_r_grant.
- o_r_resp_valid  out  1  registered one-cycle response pulse.
- o_r_resp_data  out  LINE_WIDTH  response line.
- o_r_resp_id  out  ID_WIDTH  ID of the response.
- o_mem_enable  out  1  downstream request valid.
- o_mem_addr  out  PA_WIDTH  downstream address.
- o_mem_data  out  REG_WIDTH  downstream store data.
- o_mem_write  out  1  downstream write flag.
- o_mem_id  out  ID_WIDTH  downstream ID; 0 for writes.
- i_mem_ready  in  1  downstream accepts the request in this cycle.
- i_mem_enable  in  1  response valid.
- i_mem_data  in  LINE_WIDTH  response data.
- i_mem_id_response  in  ID_WIDTH  response ID.
- o_err  out  1  sticky; set when a response carries an unallocated ID.

## Operation
- **State:** request register (enable, addr, data, write, id), `table[2^ID_WIDTH]` of {valid, owner}, `next_id`, `count` (outstanding reads), RR pointer `last`, response registers, `o_err`.
- **Slot free:** `slot_free = !o_mem_enable || i_mem_ready`.
- **Read eligibility:** a read is eligible when `count < MAX_OUTSTANDING && !table[next_id].valid`. Both terms use the registered state only.
- **Write eligibility:** writes are always eligible; they are posted and never enter the table.
- **Arbitration:**
  - With `slot_free`, exactly one eligible requester is granted.
  - If both are eligible, the requester opposite `last` wins; `last` then updates to the winner.
  - An ineligible read never blocks an eligible write from the other side.
- **On a read grant:**
  - `table[next_id]` ← {1, owner}.
  - `next_id` ← `next_id + 1`, wrapping modulo 2^ID_WIDTH.
  - `o_r_id = next_id` (the pre-increment value).
  - `count` increments.
- **Request register:** loads on a grant. Otherwise it clears o_mem_enable when `i_mem_ready` is high. It holds all fields stable while `o_mem_enable && !i_mem_ready`.
- **Response with a valid table entry** (`i_mem_enable` and `table[id].valid`):
  - Next cycle, the owner's `resp_valid` = 1, with data and id.
  - The entry is cleared and `count` decrements.
- **Response with an invalid entry:** dropped, and `o_err` ← 1.
- **Simultaneous grant and response:** `count` changes by the net amount (+1−1 = no change). An entry freed this cycle cannot be allocated until the next cycle.

## Timing
- **Reset values:** every output is 0; the table is cleared; `next_id` = 0; `count` = 0; `last` = I, so D wins the first tie. Reset acts immediately and asynchronously.
- **Grant:** `o_r_grant` is asserted in the same cycle as `i_r_req`. o_mem_enable follows on the next edge (request latency 1 cycle).
- **Downstream backpressure:** while `o_mem_enable && !i_mem_ready`, no grant is issued.
- **Back-to-back throughput:** requests can issue every cycle when `i_mem_ready` stays high.
- **Response latency:** `o_r_resp_valid` is asserted 1 cycle after `i_mem_enable` and lasts exactly 1 cycle. At most one response arrives per cycle.
- **Reset mid-transaction:** in-flight IDs are forgotten. Late responses after reset set `o_err`.

## Test plan
- **Reset:** assert rst=0 mid-run → all outputs 0; the first tie is granted to D.
- **Simultaneous reads:** I and D both request reads to 0x8000 / 0x9000 in the same cycle → D granted with id 0, I granted the next cycle with id 1. o_mem_id is 0 then 1. Responses with ids 1 then 0 route to I then D, each 1 cycle after i_mem_enable.
- **Outstanding limit:** 4 D reads with no responses → the 5th read is not granted. An I write (addr 0x100, data 0xDEADBEEF) is still granted with o_mem_id=0. Returning id 2 → the 5th read is granted the cycle after the entry frees, with id 4.
- **Backpressure:** i_mem_ready=0 for 3 cycles → o_mem_* stable, no grants issued. The first cycle after ready, the next request is granted.
- **Bad response ID:** response with id 7 while nothing is outstanding → no resp_valid pulse, o_err=1, and o_err stays 1 until reset.
- **ID wrap:** 17 sequential read/response pairs → ids go 0…15 then 0; the count returns to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I and D engines for the shared memory port.
// Tracks outstanding reads by ID and routes out-of-order responses to their owner.
module mem_arbiter #(
  parameter int PA_WIDTH        = 32,
  parameter int REG_WIDTH       = 32,
  parameter int LINE_WIDTH      = 128,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_i_req,
  input  logic [PA_WIDTH-1:0]   i_i_addr,
  input  logic [REG_WIDTH-1:0]  i_i_data,
  input  logic                  i_i_write,
  output logic                  o_i_grant,
  output logic [ID_WIDTH-1:0]   o_i_id,
  output logic                  o_i_resp_valid,
  output logic [LINE_WIDTH-1:0] o_i_resp_data,
  output logic [ID_WIDTH-1:0]   o_i_resp_id,

  input  logic                  i_d_req,
  input  logic [PA_WIDTH-1:0]   i_d_addr,
  input  logic [REG_WIDTH-1:0]  i_d_data,
  input  logic                  i_d_write,
  output logic                  o_d_grant,
  output logic [ID_WIDTH-1:0]   o_d_id,
  output logic                  o_d_resp_valid,
  output logic [LINE_WIDTH-1:0] o_d_resp_data,
  output logic [ID_WIDTH-1:0]   o_d_resp_id,

  output logic                  o_mem_enable,
  output logic [PA_WIDTH-1:0]   o_mem_addr,
  output logic [REG_WIDTH-1:0]  o_mem_data,
  output logic                  o_mem_write,
  output logic [ID_WIDTH-1:0]   o_mem_id,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_enable,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic [ID_WIDTH-1:0]   i_mem_id_response,

  output logic                  o_err
);

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEPTH = 1 << ID_WIDTH;
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [DEPTH-1:0]    r_tblValid;
  logic [DEPTH-1:0]    r_tblOwnerD;
  logic [ID_WIDTH-1:0] r_nextId;
  logic [CW-1:0]       r_count;
  owner_t              r_last;

  logic                 w_slotFree;
  logic                 w_readOk;
  logic                 w_iElig;
  logic                 w_dElig;
  logic                 w_grantI;
  logic                 w_grantD;
  logic                 w_grantAny;
  logic                 w_grantRead;
  logic                 w_winWrite;
  logic [PA_WIDTH-1:0]  w_winAddr;
  logic [REG_WIDTH-1:0] w_winData;
  logic                 w_rspHit;
  logic                 w_rspOwnerD;

  // Eligibility looks only at registered state, so a freed entry is usable next cycle.
  assign w_slotFree = !o_mem_enable || i_mem_ready;
  assign w_readOk   = (r_count < MAX_CNT) && !r_tblValid[r_nextId];
  assign w_iElig    = i_i_req && (i_i_write || w_readOk);
  assign w_dElig    = i_d_req && (i_d_write || w_readOk);

  always_comb begin
    w_grantI = 1'b0;
    w_grantD = 1'b0;
    if (rst && w_slotFree) begin
      if (w_iElig && w_dElig) begin
        if (r_last == OWN_I) begin
          w_grantD = 1'b1;
        end else begin
          w_grantI = 1'b1;
        end
      end else begin
        w_grantI = w_iElig;
        w_grantD = w_dElig;
      end
    end
  end

  assign w_grantAny  = w_grantI || w_grantD;
  assign w_grantRead = (w_grantI && !i_i_write) || (w_grantD && !i_d_write);
  assign w_winWrite  = w_grantD ? i_d_write : i_i_write;
  assign w_winAddr   = w_grantD ? i_d_addr  : i_i_addr;
  assign w_winData   = w_grantD ? i_d_data  : i_i_data;

  assign w_rspHit    = i_mem_enable && r_tblValid[i_mem_id_response];
  assign w_rspOwnerD = r_tblOwnerD[i_mem_id_response];

  assign o_i_grant = w_grantI;
  assign o_d_grant = w_grantD;
  assign o_i_id    = (w_grantI && !i_i_write) ? r_nextId : '0;
  assign o_d_id    = (w_grantD && !i_d_write) ? r_nextId : '0;

  // Single downstream slot: loads the winner, drains on ready, holds under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_mem_enable <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_mem_write  <= 1'b0;
      o_mem_id     <= '0;
    end else if (w_grantAny) begin
      o_mem_enable <= 1'b1;
      o_mem_addr   <= w_winAddr;
      o_mem_data   <= w_winData;
      o_mem_write  <= w_winWrite;
      o_mem_id     <= w_winWrite ? '0 : r_nextId;
    end else if (i_mem_ready) begin
      o_mem_enable <= 1'b0;
    end
  end

  // A response hit and a read allocation never touch the same entry in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tblValid  <= '0;
      r_tblOwnerD <= '0;
      r_nextId    <= '0;
      r_count     <= '0;
      r_last      <= OWN_I;
    end else begin
      if (w_grantAny) begin
        r_last <= w_grantD ? OWN_D : OWN_I;
      end
      if (w_rspHit) begin
        r_tblValid[i_mem_id_response] <= 1'b0;
      end
      if (w_grantRead) begin
        r_tblValid[r_nextId]  <= 1'b1;
        r_tblOwnerD[r_nextId] <= w_grantD;
        r_nextId              <= r_nextId + ID_WIDTH'(1);
      end
      case ({w_grantRead, w_rspHit})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_i_resp_valid <= 1'b0;
      o_i_resp_data  <= '0;
      o_i_resp_id    <= '0;
      o_d_resp_valid <= 1'b0;
      o_d_resp_data  <= '0;
      o_d_resp_id    <= '0;
      o_err          <= 1'b0;
    end else begin
      o_i_resp_valid <= w_rspHit && !w_rspOwnerD;
      o_d_resp_valid <= w_rspHit && w_rspOwnerD;
      if (w_rspHit && !w_rspOwnerD) begin
        o_i_resp_data <= i_mem_data;
        o_i_resp_id   <= i_mem_id_response;
      end
      if (w_rspHit && w_rspOwnerD) begin
        o_d_resp_data <= i_mem_data;
        o_d_resp_id   <= i_mem_id_response;
      end
      if (i_mem_enable && !r_tblValid[i_mem_id_response]) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector tables for the corner cases, then
// randomized traffic checked against a transaction-level reference model.
module tb_mem_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_i_req, i_i_write, i_d_req, i_d_write;
  logic [31:0]   i_i_addr, i_i_data, i_d_addr, i_d_data;
  logic          o_i_grant, o_d_grant, o_i_resp_valid, o_d_resp_valid;
  logic [3:0]    o_i_id, o_d_id, o_i_resp_id, o_d_resp_id;
  logic [127:0]  o_i_resp_data, o_d_resp_data;
  logic          o_mem_enable, o_mem_write, i_mem_ready, i_mem_enable, o_err;
  logic [31:0]   o_mem_addr, o_mem_data;
  logic [3:0]    o_mem_id, i_mem_id_response;
  logic [127:0]  i_mem_data;

  int checks   = 0;
  int failures = 0;
  logic errNow = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .PA_WIDTH(32), .REG_WIDTH(32), .LINE_WIDTH(128), .ID_WIDTH(4), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_i_req(i_i_req), .i_i_addr(i_i_addr), .i_i_data(i_i_data), .i_i_write(i_i_write),
    .o_i_grant(o_i_grant), .o_i_id(o_i_id), .o_i_resp_valid(o_i_resp_valid),
    .o_i_resp_data(o_i_resp_data), .o_i_resp_id(o_i_resp_id),
    .i_d_req(i_d_req), .i_d_addr(i_d_addr), .i_d_data(i_d_data), .i_d_write(i_d_write),
    .o_d_grant(o_d_grant), .o_d_id(o_d_id), .o_d_resp_valid(o_d_resp_valid),
    .o_d_resp_data(o_d_resp_data), .o_d_resp_id(o_d_resp_id),
    .o_mem_enable(o_mem_enable), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_write(o_mem_write), .o_mem_id(o_mem_id), .i_mem_ready(i_mem_ready),
    .i_mem_enable(i_mem_enable), .i_mem_data(i_mem_data),
    .i_mem_id_response(i_mem_id_response), .o_err(o_err)
  );

  typedef struct {
    logic        iReq, iWrite, dReq, dWrite, ready, rspEn;
    logic [31:0] iAddr, iData, dAddr, dData;
    logic [3:0]  rspId;
    logic        expGI, expGD;
    logic [3:0]  expIdI, expIdD;
    logic        expMemEn, expMemWrite;
    logic [31:0] expMemAddr, expMemData;
    logic [3:0]  expMemId;
    logic        expRI, expRD;
    logic [3:0]  expRspId;
    logic        expErr;
  } vec_t;

  vec_t rows[$];

  function automatic vec_t idle();
    vec_t v;
    v        = '{default: '0};
    v.ready  = 1'b1;
    v.expErr = errNow;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_i_req           = v.iReq;
    i_i_write         = v.iWrite;
    i_i_addr          = v.iAddr;
    i_i_data          = v.iData;
    i_d_req           = v.dReq;
    i_d_write         = v.dWrite;
    i_d_addr          = v.dAddr;
    i_d_data          = v.dData;
    i_mem_ready       = v.ready;
    i_mem_enable      = v.rspEn;
    i_mem_id_response = v.rspId;
    i_mem_data        = {4{28'hA5A5A5A, v.rspId}};
  endtask

  task automatic checkRow(input vec_t v, input string tag, input int idx);
    string p;
    p = $sformatf("%s[%0d]", tag, idx);
    checkOutput({p, ".grant"}, 128'({o_i_grant, o_d_grant, o_i_id, o_d_id}),
                128'({v.expGI, v.expGD, v.expIdI, v.expIdD}));
    checkOutput({p, ".memEn"}, 128'(o_mem_enable), 128'(v.expMemEn));
    if (v.expMemEn) begin
      checkOutput({p, ".memReq"}, 128'({o_mem_addr, o_mem_write, o_mem_id}),
                  128'({v.expMemAddr, v.expMemWrite, v.expMemId}));
      if (v.expMemWrite) checkOutput({p, ".memData"}, 128'(o_mem_data), 128'(v.expMemData));
    end
    checkOutput({p, ".respValid"}, 128'({o_i_resp_valid, o_d_resp_valid}), 128'({v.expRI, v.expRD}));
    if (v.expRI) checkOutput({p, ".respIdI"}, 128'(o_i_resp_id), 128'(v.expRspId));
    if (v.expRD) checkOutput({p, ".respIdD"}, 128'(o_d_resp_id), 128'(v.expRspId));
    checkOutput({p, ".err"}, 128'(o_err), 128'(v.expErr));
  endtask

  task automatic runTable(input string tag);
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk);
      #1 applyStimulus(rows[i]);
      #6 checkRow(rows[i], tag, i);
    end
    rows.delete();
  endtask

  // Reset is asserted away from any edge with requests pending, so both the
  // asynchronous clear and the grant gating are visible before the next edge.
  task automatic doReset(input string tag);
    i_i_req = 1'b1; i_i_write = 1'b0; i_i_addr = 32'h7000;
    i_d_req = 1'b1; i_d_write = 1'b0; i_d_addr = 32'h7100;
    i_mem_ready = 1'b1; i_mem_enable = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput({tag, ".ctl"}, 128'({o_i_grant, o_d_grant, o_i_id, o_d_id, o_mem_enable, o_mem_write,
                o_mem_id, o_i_resp_valid, o_d_resp_valid, o_i_resp_id, o_d_resp_id, o_err}), 128'(0));
    checkOutput({tag, ".memBus"}, 128'({o_mem_addr, o_mem_data}), 128'(0));
    checkOutput({tag, ".respData"}, o_i_resp_data | o_d_resp_data, 128'(0));
    @(negedge clk);
    @(negedge clk);
    i_i_req = 1'b0;
    i_d_req = 1'b0;
    rst     = 1'b1;
    errNow  = 1'b0;
  endtask

  // Reference model: an ID -> owner map, the in-flight downstream request and
  // per-requester pending requests, advanced once per clock.
  int          ownerOf[16];
  int          nextId, lastWin;
  logic        mEn, mWrite;
  logic [31:0] mAddr, mData;
  logic [3:0]  mId;
  logic        eRV[2];
  logic [127:0] eRD[2];
  logic [3:0]  eRI[2];
  logic        eErr;
  logic        pAct[2], pWr[2];
  logic [31:0] pAd[2], pDa[2];

  task automatic runRandom(input int cycles);
    int q[$];
    int win, hit, rid;
    logic free, readOk;
    logic elig[2];
    logic [3:0] eid[2];
    for (int s = 0; s < 16; s++) ownerOf[s] = -1;
    nextId = 0; lastWin = 0; mEn = 0; mWrite = 0; mAddr = 0; mData = 0; mId = 0; eErr = 0;
    for (int s = 0; s < 2; s++) begin
      eRV[s] = 0; eRD[s] = 0; eRI[s] = 0; pAct[s] = 0; pWr[s] = 0; pAd[s] = 0; pDa[s] = 0;
    end
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
        if (!pAct[s] && $urandom_range(0, 2) == 0) begin
          pAct[s] = 1'b1;
          pWr[s]  = ($urandom_range(0, 3) == 0);
          pAd[s]  = $urandom;
          pDa[s]  = $urandom;
        end
      end
      q.delete();
      for (int s = 0; s < 16; s++) if (ownerOf[s] >= 0) q.push_back(s);
      i_mem_enable = 1'b0;
      rid = 0;
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        i_mem_enable = 1'b1;
        rid = q[$urandom_range(0, q.size() - 1)];
      end else if ($urandom_range(0, 199) == 0) begin
        i_mem_enable = 1'b1;
        rid = $urandom_range(0, 15);
      end
      i_mem_id_response = 4'(rid);
      i_mem_data  = {$urandom, $urandom, $urandom, $urandom};
      i_mem_ready = ($urandom_range(0, 3) != 0);
      i_i_req = pAct[0]; i_i_write = pWr[0]; i_i_addr = pAd[0]; i_i_data = pDa[0];
      i_d_req = pAct[1]; i_d_write = pWr[1]; i_d_addr = pAd[1]; i_d_data = pDa[1];
      #6;
      free   = !mEn || i_mem_ready;
      readOk = (q.size() < 4) && (ownerOf[nextId] < 0);
      for (int s = 0; s < 2; s++) elig[s] = pAct[s] && (pWr[s] || readOk);
      win = -1;
      if (free) begin
        if (elig[0] && elig[1]) win = (lastWin == 0) ? 1 : 0;
        else if (elig[0]) win = 0;
        else if (elig[1]) win = 1;
      end
      for (int s = 0; s < 2; s++) eid[s] = (win == s && !pWr[s]) ? 4'(nextId) : 4'd0;
      checkOutput("rnd.grant", 128'({o_i_grant, o_d_grant, o_i_id, o_d_id}),
                  128'({win == 0, win == 1, eid[0], eid[1]}));
      checkOutput("rnd.memEn", 128'(o_mem_enable), 128'(mEn));
      if (mEn) begin
        checkOutput("rnd.memReq", 128'({o_mem_addr, o_mem_write, o_mem_id}), 128'({mAddr, mWrite, mId}));
        if (mWrite) checkOutput("rnd.memData", 128'(o_mem_data), 128'(mData));
      end
      checkOutput("rnd.respValid", 128'({o_i_resp_valid, o_d_resp_valid}), 128'({eRV[0], eRV[1]}));
      if (eRV[0]) checkOutput("rnd.respI", {o_i_resp_data[127:4], o_i_resp_id}, {eRD[0][127:4], eRI[0]});
      if (eRV[1]) checkOutput("rnd.respD", {o_d_resp_data[127:4], o_d_resp_id}, {eRD[1][127:4], eRI[1]});
      if (eRV[0]) checkOutput("rnd.respDataI", 128'(o_i_resp_data[3:0]), 128'(eRD[0][3:0]));
      if (eRV[1]) checkOutput("rnd.respDataD", 128'(o_d_resp_data[3:0]), 128'(eRD[1][3:0]));
      checkOutput("rnd.err", 128'(o_err), 128'(eErr));
      hit = (i_mem_enable && ownerOf[rid] >= 0) ? 1 : 0;
      for (int s = 0; s < 2; s++) begin
        eRV[s] = (hit == 1) && (ownerOf[rid] == s);
        if (eRV[s]) begin
          eRD[s] = i_mem_data;
          eRI[s] = 4'(rid);
        end
      end
      if (i_mem_enable && hit == 0) eErr = 1'b1;
      if (hit == 1) ownerOf[rid] = -1;
      if (win >= 0) begin
        mEn = 1'b1; mAddr = pAd[win]; mData = pDa[win]; mWrite = pWr[win];
        mId = pWr[win] ? 4'd0 : 4'(nextId);
        if (!pWr[win]) begin
          ownerOf[nextId] = win;
          nextId = (nextId + 1) % 16;
        end
        lastWin = win;
        pAct[win] = 1'b0;
      end else if (i_mem_ready) begin
        mEn = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t v;
    applyStimulus(idle());
    #2;
    doReset("rst0");

    // Tie, ID order, out-of-order routing, bad ID, write tie, backpressure.
    v = idle(); v.iReq = 1; v.iAddr = 32'h8000; v.dReq = 1; v.dAddr = 32'h9000; v.expGD = 1; rows.push_back(v);
    v = idle(); v.iReq = 1; v.iAddr = 32'h8000; v.expGI = 1; v.expIdI = 1;
    v.expMemEn = 1; v.expMemAddr = 32'h9000; v.expMemId = 0; rows.push_back(v);
    v = idle(); v.expMemEn = 1; v.expMemAddr = 32'h8000; v.expMemId = 1; rows.push_back(v);
    v = idle(); v.rspEn = 1; v.rspId = 1; rows.push_back(v);
    v = idle(); v.rspEn = 1; v.rspId = 0; v.expRI = 1; v.expRspId = 1; rows.push_back(v);
    v = idle(); v.expRD = 1; v.expRspId = 0; rows.push_back(v);
    v = idle(); v.rspEn = 1; v.rspId = 7; rows.push_back(v);
    errNow = 1'b1;
    v = idle(); rows.push_back(v);
    v = idle(); v.iReq = 1; v.iWrite = 1; v.iAddr = 32'h100; v.iData = 32'h1111_1111;
    v.dReq = 1; v.dWrite = 1; v.dAddr = 32'h200; v.dData = 32'h2222_2222; v.expGD = 1; rows.push_back(v);
    v = idle(); v.iReq = 1; v.iWrite = 1; v.iAddr = 32'h100; v.iData = 32'h1111_1111; v.expGI = 1;
    v.expMemEn = 1; v.expMemWrite = 1; v.expMemAddr = 32'h200; v.expMemData = 32'h2222_2222; rows.push_back(v);
    for (int k = 0; k < 4; k++) begin
      v = idle(); v.ready = (k == 3); v.dReq = 1; v.dAddr = 32'h300;
      v.expMemEn = 1; v.expMemWrite = 1; v.expMemAddr = 32'h100; v.expMemData = 32'h1111_1111;
      if (k == 3) begin v.expGD = 1; v.expIdD = 2; end
      rows.push_back(v);
    end
    v = idle(); v.expMemEn = 1; v.expMemAddr = 32'h300; v.expMemId = 2; rows.push_back(v);
    v = idle(); v.rspEn = 1; v.rspId = 2; rows.push_back(v);
    v = idle(); v.expRD = 1; v.expRspId = 2; rows.push_back(v);
    runTable("basic");

    doReset("rst1");
    // Outstanding limit with a write slipping past the blocked read.
    for (int k = 0; k < 4; k++) begin
      v = idle(); v.dReq = 1; v.dAddr = 32'h1000 + k * 16; v.expGD = 1; v.expIdD = 4'(k);
      if (k > 0) begin v.expMemEn = 1; v.expMemAddr = 32'h1000 + (k - 1) * 16; v.expMemId = 4'(k - 1); end
      rows.push_back(v);
    end
    v = idle(); v.dReq = 1; v.dAddr = 32'h1040; v.iReq = 1; v.iWrite = 1; v.iAddr = 32'h100;
    v.iData = 32'hDEAD_BEEF; v.expGI = 1; v.expMemEn = 1; v.expMemAddr = 32'h1030; v.expMemId = 3; rows.push_back(v);
    v = idle(); v.dReq = 1; v.dAddr = 32'h1040; v.expMemEn = 1; v.expMemWrite = 1;
    v.expMemAddr = 32'h100; v.expMemData = 32'hDEAD_BEEF; v.expMemId = 0; rows.push_back(v);
    v = idle(); v.dReq = 1; v.dAddr = 32'h1040; v.rspEn = 1; v.rspId = 2; rows.push_back(v);
    v = idle(); v.dReq = 1; v.dAddr = 32'h1040; v.expGD = 1; v.expIdD = 4; v.expRD = 1; v.expRspId = 2; rows.push_back(v);
    v = idle(); v.expMemEn = 1; v.expMemAddr = 32'h1040; v.expMemId = 4; rows.push_back(v);
    runTable("limit");

    doReset("rst2");
    // Late response after reset, then the first tie still goes to D.
    v = idle(); v.rspEn = 1; v.rspId = 0; rows.push_back(v);
    errNow = 1'b1;
    v = idle(); v.iReq = 1; v.iAddr = 32'h500; v.dReq = 1; v.dAddr = 32'h600; v.expGD = 1; rows.push_back(v);
    v = idle(); v.iReq = 1; v.iAddr = 32'h500; v.expGI = 1; v.expIdI = 1;
    v.expMemEn = 1; v.expMemAddr = 32'h600; v.expMemId = 0; rows.push_back(v);
    v = idle(); v.expMemEn = 1; v.expMemAddr = 32'h500; v.expMemId = 1; rows.push_back(v);
    runTable("late");

    doReset("rst3");
    // 17 read/response pairs wrap the ID; then 4 more reads prove count drained to 0.
    for (int k = 0; k < 17; k++) begin
      v = idle(); v.iReq = 1; v.iAddr = 32'h4000 + k * 16; v.expGI = 1; v.expIdI = 4'(k % 16); rows.push_back(v);
      v = idle(); v.expMemEn = 1; v.expMemAddr = 32'h4000 + k * 16; v.expMemId = 4'(k % 16); rows.push_back(v);
      v = idle(); v.rspEn = 1; v.rspId = 4'(k % 16); rows.push_back(v);
      v = idle(); v.expRI = 1; v.expRspId = 4'(k % 16); rows.push_back(v);
    end
    for (int k = 0; k < 6; k++) begin
      v = idle(); v.dReq = 1; v.dAddr = 32'h2000 + ((k < 4) ? k : 4) * 4;
      if (k < 4) begin v.expGD = 1; v.expIdD = 4'(k + 1); end
      if (k > 0 && k < 5) begin
        v.expMemEn = 1; v.expMemAddr = 32'h2000 + (k - 1) * 4; v.expMemId = 4'(k);
      end
      rows.push_back(v);
    end
    runTable("wrap");

    doReset("rst4");
    runRandom(3000);

    applyStimulus(idle());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
